// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, idle line value,
// and the default button debounce length.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } tx_state_t;

   // tx_Data is filled with this bit when idle, matching the UART mark level
   localparam logic        TX_IDLE_BIT           = 1'b1;
   localparam int unsigned DEFAULT_DEBOUNCE_TIME = 100;

endpackage

// File: rtl/uart_debounce.sv
// Button debouncer: emits a single-cycle pulse once the input has stayed high
// for DEBOUNCE_TIME cycles; holding the button never re-fires.
module uart_debounce
   import uart_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TIME = DEFAULT_DEBOUNCE_TIME
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_button,
   output logic o_pulse
);

   localparam int unsigned CW = $clog2(DEBOUNCE_TIME + 1);
   localparam logic [CW-1:0] C_MAX  = CW'(DEBOUNCE_TIME);
   localparam logic [CW-1:0] C_FIRE = CW'(DEBOUNCE_TIME - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (!i_button) begin
         r_cnt <= '0;
      end else if (r_cnt != C_MAX) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Counter passes through DEBOUNCE_TIME-1 only once per press, then saturates
   assign o_pulse = (r_cnt == C_FIRE);

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter, popped one entry per debounced trigger.
// Define UART_TX_FIFO_BURST_EN to drain the whole FIFO on a single trigger.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned FIFO_DEPTH    = 16,
   parameter int unsigned PTR_SIZE      = 4,
   parameter int unsigned DEBOUNCE_TIME = DEFAULT_DEBOUNCE_TIME
) (
   input  logic                  sample_Clk,
   input  logic                  reset,
   input  logic                  button_Trig,
   input  logic                  wr_Sig,
   input  logic [DATA_WIDTH-1:0] wr_Data,
   input  logic                  tx_Busy,
   output logic                  tx_Start,
   output logic [DATA_WIDTH-1:0] tx_Data,
   output logic                  sig_Full,
   output logic                  sig_Empty,
   output logic [PTR_SIZE:0]     sig_Count,
   output logic                  sig_Overflow
);

   localparam int unsigned CNT_W = PTR_SIZE + 1;
   localparam logic [PTR_SIZE:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_SIZE-1:0]   r_wr_ptr;
   logic [PTR_SIZE-1:0]   r_rd_ptr;
   tx_state_t             r_state;
   tx_state_t             w_state_nxt;
   logic                  w_trig;
   logic                  w_pop;
   logic                  w_push;
   logic [PTR_SIZE:0]     w_count_nxt;

   uart_debounce #(.DEBOUNCE_TIME(DEBOUNCE_TIME)) u_debounce (
      .i_clk    (sample_Clk),
      .i_rst    (reset),
      .i_button (button_Trig),
      .o_pulse  (w_trig)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_trig && !sig_Empty && !tx_Busy) w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            w_pop       = 1'b1;
            w_state_nxt = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_Busy) w_state_nxt = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (!tx_Busy) begin
`ifdef UART_TX_FIFO_BURST_EN
               w_state_nxt = sig_Empty ? ST_IDLE : ST_ISSUE;
`else
               w_state_nxt = ST_IDLE;
`endif
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // A full FIFO still accepts a push in the cycle an entry is popped
   assign w_push = wr_Sig && (!sig_Full || w_pop);

   always_comb begin
      w_count_nxt = sig_Count;
      if (w_push && !w_pop) begin
         w_count_nxt = sig_Count + 1'b1;
      end else if (w_pop && !w_push) begin
         w_count_nxt = sig_Count - 1'b1;
      end
   end

   always_ff @(posedge sample_Clk) begin
      if (!reset && w_push) r_mem[r_wr_ptr] <= wr_Data;
   end

   always_ff @(posedge sample_Clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         sig_Count    <= '0;
         sig_Empty    <= 1'b1;
         sig_Full     <= 1'b0;
         sig_Overflow <= 1'b0;
         tx_Start     <= 1'b0;
         tx_Data      <= {DATA_WIDTH{TX_IDLE_BIT}};
      end else begin
         r_state   <= w_state_nxt;
         tx_Start  <= w_pop;
         sig_Count <= w_count_nxt;
         sig_Empty <= (w_count_nxt == '0);
         sig_Full  <= (w_count_nxt == C_DEPTH);
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            tx_Data  <= r_mem[r_rd_ptr];
         end
         if (wr_Sig && sig_Full && !w_pop) sig_Overflow <= 1'b1;
      end
   end

endmodule
